// File: rtl/vram_console.sv
// Purpose: turns a byte stream into VRAM writes for a 40x30 text screen (cursor, wrap, control codes, clears).
// Latency: the write for an accepted byte is on vram_* in the cycle after the transfer edge.
// Backpressure: in_ready is low throughout a row blank or full-screen clear and high otherwise.
module vram_console #(
  parameter int          COLS = 40,
  parameter int          ROWS = 30,
  parameter logic [7:0]  FILL = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [10:0] vram_waddr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  output logic [5:0]  cursor_x,
  output logic [4:0]  cursor_y
);

  localparam int          TOTAL    = COLS * ROWS;
  localparam logic [5:0]  LAST_COL = 6'(COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
  localparam logic [10:0] ROW_STEP = 11'(COLS);
  // Counters run one past the last write so the idle return lands in the
  // cycle after the final fill write, not on top of it.
  localparam logic [11:0] CLR_END  = 12'(TOTAL);
  localparam logic [11:0] LINE_END = 12'(COLS);

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  typedef enum logic [1:0] {
    S_CLEAR   = 2'd0,
    S_IDLE    = 2'd1,
    S_LINECLR = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [5:0]  x_q, x_d;
  logic [4:0]  y_q, y_d;
  logic [10:0] row_base_q, row_base_d;
  logic        we_q, we_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;

  logic        xfer;
  logic [4:0]  adv_y;
  logic [10:0] adv_row_base;
  logic [10:0] cur_addr;
  logic [10:0] bs_addr;
  logic [5:0]  x_dec;

  assign in_ready = (state_q == S_IDLE);
  assign xfer     = in_valid && in_ready;

  // Row advance wraps to the top; row_base tracks y*COLS without a multiplier.
  assign adv_y        = (y_q == LAST_ROW) ? 5'd0  : y_q + 5'd1;
  assign adv_row_base = (y_q == LAST_ROW) ? 11'd0 : row_base_q + ROW_STEP;

  assign x_dec    = x_q - 6'd1;
  assign cur_addr = row_base_q + {5'd0, x_q};
  assign bs_addr  = row_base_q + {5'd0, x_dec};

  // Next-state, cursor and write-port decode; vram_we defaults low every cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    row_base_d = row_base_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;

    case (state_q)
      S_CLEAR: begin
        if (cnt_q < CLR_END) begin
          we_d   = 1'b1;
          addr_d = cnt_q[10:0];
          data_d = FILL;
          cnt_d  = cnt_q + 12'd1;
        end else begin
          state_d = S_IDLE;
          cnt_d   = 12'd0;
        end
      end

      S_LINECLR: begin
        if (cnt_q < LINE_END) begin
          we_d   = 1'b1;
          addr_d = row_base_q + cnt_q[10:0];
          data_d = FILL;
          cnt_d  = cnt_q + 12'd1;
        end else begin
          state_d = S_IDLE;
          cnt_d   = 12'd0;
        end
      end

      S_IDLE: begin
        if (xfer) begin
          case (in_data)
            CH_CR: begin
              x_d = 6'd0;
            end

            CH_LF: begin
              // First blank cell goes out on the transfer edge itself.
              x_d        = 6'd0;
              y_d        = adv_y;
              row_base_d = adv_row_base;
              we_d       = 1'b1;
              addr_d     = adv_row_base;
              data_d     = FILL;
              cnt_d      = 12'd1;
              state_d    = S_LINECLR;
            end

            CH_BS: begin
              if (x_q != 6'd0) begin
                x_d    = x_dec;
                we_d   = 1'b1;
                addr_d = bs_addr;
                data_d = FILL;
              end
            end

            CH_FF: begin
              // Clear sweep starts at address 0 on the transfer edge.
              x_d        = 6'd0;
              y_d        = 5'd0;
              row_base_d = 11'd0;
              we_d       = 1'b1;
              addr_d     = 11'd0;
              data_d     = FILL;
              cnt_d      = 12'd1;
              state_d    = S_CLEAR;
            end

            default: begin
              we_d   = 1'b1;
              addr_d = cur_addr;
              data_d = in_data;
              if (x_q < LAST_COL) begin
                x_d = x_q + 6'd1;
              end else begin
                // Character occupies this edge; the new row is blanked afterwards.
                x_d        = 6'd0;
                y_d        = adv_y;
                row_base_d = adv_row_base;
                cnt_d      = 12'd0;
                state_d    = S_LINECLR;
              end
            end
          endcase
        end
      end

      default: begin
        state_d = S_CLEAR;
        cnt_d   = 12'd0;
      end
    endcase
  end

  // State and output registers; reset aborts any fill and restarts the clear at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      cnt_q      <= 12'd0;
      x_q        <= 6'd0;
      y_q        <= 5'd0;
      row_base_q <= 11'd0;
      we_q       <= 1'b0;
      addr_q     <= 11'd0;
      data_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign vram_we    = we_q;
  assign vram_waddr = addr_q;
  assign vram_wdata = data_q;
  assign cursor_x   = x_q;
  assign cursor_y   = y_q;

endmodule

// File: tb/tb_vram_console.sv
// Purpose: directed self-checking bench for vram_console (clears, wrap, control codes, reset abort).
// Latency: outputs are sampled on the falling edge, half a cycle after the edge that produced them.
// Backpressure: every byte send waits on in_ready under a bounded cycle budget.
module tb_vram_console;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] vram_waddr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic [5:0]  cursor_x;
  logic [4:0]  cursor_y;

  int checks   = 0;
  int failures = 0;

  vram_console dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .vram_waddr (vram_waddr),
    .vram_wdata (vram_wdata),
    .vram_we    (vram_we),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) check("ready_timeout", {31'd0, in_ready}, 32'd1);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Expects n consecutive FILL writes base..base+n-1 with in_ready low throughout.
  task automatic expect_fill(input string tag, input int base, input int n);
    int errs;
    int low;
    errs = 0;
    low  = 0;
    for (int i = 0; i < n; i++) begin
      if (!(vram_we === 1'b1 && vram_waddr === 11'(base + i) && vram_wdata === 8'h20)) errs++;
      if (in_ready === 1'b0) low++;
      @(negedge clk);
    end
    check({tag, "_seq_errs"}, errs, 0);
    check({tag, "_ready_low"}, low, n);
  endtask

  task automatic expect_cursor(input string tag, input int x, input int y);
    check({tag, "_x"}, {26'd0, cursor_x}, x);
    check({tag, "_y"}, {27'd0, cursor_y}, y);
  endtask

  initial begin
    reset    = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_we", {31'd0, vram_we}, 0);
    check("rst_addr", {21'd0, vram_waddr}, 0);
    check("rst_data", {24'd0, vram_wdata}, 0);
    check("rst_ready", {31'd0, in_ready}, 0);
    expect_cursor("rst_cur", 0, 0);
    reset = 1'b0;

    // Power-on clear: 1200 fills, then ready and quiet
    @(negedge clk);
    expect_fill("clr", 0, 1200);
    check("clr_done_ready", {31'd0, in_ready}, 1);
    check("clr_done_we", {31'd0, vram_we}, 0);
    expect_cursor("clr_cur", 0, 0);
    begin
      int stray;
      stray = 0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (vram_we !== 1'b0) stray++;
      end
      check("idle_no_write", stray, 0);
    end

    // "AB" back-to-back
    in_data  = 8'h41;
    in_valid = 1'b1;
    @(negedge clk);
    check("a_we", {31'd0, vram_we}, 1);
    check("a_addr", {21'd0, vram_waddr}, 0);
    check("a_data", {24'd0, vram_wdata}, 8'h41);
    check("a_ready", {31'd0, in_ready}, 1);
    expect_cursor("a_cur", 1, 0);
    in_data = 8'h42;
    @(negedge clk);
    check("b_we", {31'd0, vram_we}, 1);
    check("b_addr", {21'd0, vram_waddr}, 1);
    check("b_data", {24'd0, vram_wdata}, 8'h42);
    check("b_ready", {31'd0, in_ready}, 1);
    expect_cursor("b_cur", 2, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("ab_after_we", {31'd0, vram_we}, 0);

    // Move to (5,3), then LF blanks row 4
    for (int i = 0; i < 3; i++) send_byte(8'h0A);
    for (int i = 0; i < 5; i++) send_byte(8'h68);
    expect_cursor("pre_lf_cur", 5, 3);
    send_byte(8'h0A);
    expect_cursor("lf_cur", 0, 4);
    expect_fill("lf", 160, 40);
    check("lf_ready_back", {31'd0, in_ready}, 1);
    check("lf_we_off", {31'd0, vram_we}, 0);

    // Form feed: full clear from address 0
    send_byte(8'h0C);
    expect_cursor("ff_cur", 0, 0);
    expect_fill("ff", 0, 1200);
    check("ff_ready_back", {31'd0, in_ready}, 1);

    // Move to (39,29), then a wrapping character at the bottom-right cell
    for (int i = 0; i < 29; i++) send_byte(8'h0A);
    for (int i = 0; i < 39; i++) send_byte(8'h61);
    expect_cursor("pre_wrap_cur", 39, 29);
    send_byte(8'h58);
    check("wrap_we", {31'd0, vram_we}, 1);
    check("wrap_addr", {21'd0, vram_waddr}, 1199);
    check("wrap_data", {24'd0, vram_wdata}, 8'h58);
    check("wrap_ready", {31'd0, in_ready}, 0);
    expect_cursor("wrap_cur", 0, 0);
    @(negedge clk);
    expect_fill("wrap", 0, 40);
    check("wrap_ready_back", {31'd0, in_ready}, 1);

    // Backspace at column 0 is a no-op
    send_byte(8'h08);
    check("bs0_we", {31'd0, vram_we}, 0);
    expect_cursor("bs0_cur", 0, 0);

    // Backspace from (7,2), then CR
    send_byte(8'h0A);
    send_byte(8'h0A);
    for (int i = 0; i < 7; i++) send_byte(8'h62);
    expect_cursor("pre_bs_cur", 7, 2);
    send_byte(8'h08);
    check("bs_we", {31'd0, vram_we}, 1);
    check("bs_addr", {21'd0, vram_waddr}, 86);
    check("bs_data", {24'd0, vram_wdata}, 8'h20);
    expect_cursor("bs_cur", 6, 2);
    send_byte(8'h0D);
    check("cr_we", {31'd0, vram_we}, 0);
    check("cr_ready", {31'd0, in_ready}, 1);
    expect_cursor("cr_cur", 0, 2);

    // Reset in the middle of a form-feed clear
    send_byte(8'h0C);
    expect_fill("ffpart", 0, 500);
    reset = 1'b1;
    #1;
    check("midrst_we", {31'd0, vram_we}, 0);
    check("midrst_addr", {21'd0, vram_waddr}, 0);
    check("midrst_data", {24'd0, vram_wdata}, 0);
    check("midrst_ready", {31'd0, in_ready}, 0);
    expect_cursor("midrst_cur", 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    expect_fill("reclr", 0, 1200);
    check("reclr_ready", {31'd0, in_ready}, 1);
    check("reclr_we", {31'd0, vram_we}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
